// File: rtl/timing_nco_pkg.sv
// Shared definitions for the timing-recovery NCO and the interpolator.
// Float format: 1 sign, 8 exponent (bias 127), 10 mantissa, hidden one.
package timing_nco_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 10;
    localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;
    localparam int FP_BIAS  = 127;

    // Fractional interval is carried as unsigned Q0.10 before conversion
    localparam int Q_W      = 10;
    localparam int LEAD_W   = $clog2(Q_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_CONV = 2'd2
    } nco_state_e;

endpackage

// File: rtl/timing_nco_fix2fp.sv
// Q0.10 unsigned fraction to float normaliser, truncating.
// Zero maps to the all-zero word; otherwise sign is always 0.
module fix2fp
    import timing_nco_pkg::*;
(
    input  logic [Q_W-1:0]  q_i,
    output logic [FP_W-1:0] fp_o
);

    logic [LEAD_W-1:0]   lead;
    logic [FP_MAN_W-1:0] man;
    logic [FP_EXP_W-1:0] expo;

    // Find the leading one, shift it out, left-align the remaining bits
    always_comb begin
        lead = '0;
        for (int i = 0; i < Q_W; i++) begin
            if (q_i[i]) lead = LEAD_W'(i);
        end
        man  = FP_MAN_W'(q_i << (LEAD_W'(Q_W) - lead));
        expo = FP_EXP_W'(FP_BIAS - Q_W) + FP_EXP_W'(lead);
        fp_o = (q_i == '0) ? '0 : {1'b0, expo, man};
    end

endmodule

// File: rtl/timing_nco.sv
// Timing-recovery NCO: down-counting phase accumulator whose borrow
// marks a new symbol; the fractional interval mu = eta/W is emitted as float.
module timing_nco
    import timing_nco_pkg::*;
#(
    parameter int DATA_WIDTH = 19,
    parameter int NCO_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NCO_WIDTH-1:0]  ctrl_word,
    input  logic                  ctrl_valid,
    output logic                  nco_uf,
    output logic [DATA_WIDTH-1:0] mu,
    output logic                  mu_valid,
    output logic                  overrun
);

    localparam logic [NCO_WIDTH-1:0] ETA_RST = {1'b1, {(NCO_WIDTH-1){1'b0}}};
    localparam logic [3:0]           DIV_LAST = 4'(Q_W - 1);

    logic [NCO_WIDTH-1:0]  eta_q, w_q;
    logic                  uf_q, ovr_q;
    logic                  uf;

    nco_state_e            state_q, state_d;
    logic [NCO_WIDTH-1:0]  rem_q, rem_d;
    logic [NCO_WIDTH-1:0]  dvs_q, dvs_d;
    logic [Q_W-1:0]        quo_q, quo_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [FP_W-1:0]       fp_q, fp_d;
    logic [DATA_WIDTH-1:0] mu_q, mu_d;
    logic                  mv_q, mv_d;

    logic [FP_W-1:0]       fp_w;
    logic [NCO_WIDTH:0]    trial, diff;
    logic                  ge;

    // Borrow on this step; a zero step can never borrow
    assign uf = en && (w_q != '0) && (eta_q < w_q);

    // Phase accumulator, step register and event flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eta_q <= ETA_RST;
            w_q   <= '0;
            uf_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (ctrl_valid) w_q <= ctrl_word;
            if (en) eta_q <= eta_q - w_q;
            uf_q <= uf;
            if (uf && state_q != ST_IDLE) ovr_q <= 1'b1;
        end
    end

    fix2fp u_fix2fp (
        .q_i  (quo_q),
        .fp_o (fp_w)
    );

    // Restoring-division trial subtract, one quotient bit per cycle
    always_comb begin
        trial = {rem_q, 1'b0};
        diff  = trial - {1'b0, dvs_q};
        ge    = (trial >= {1'b0, dvs_q});
    end

    // Divider / converter sequencing and datapath next state
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        fp_d    = fp_q;
        mu_d    = mu_q;
        mv_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (uf) begin
                    rem_d   = eta_q;
                    dvs_d   = w_q;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                rem_d = NCO_WIDTH'(ge ? diff : trial);
                quo_d = {quo_q[Q_W-2:0], ge};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                // First cycle captures the normaliser, second publishes it
                if (cnt_q == '0) begin
                    fp_d  = fp_w;
                    cnt_d = 4'd1;
                end else begin
                    mu_d    = DATA_WIDTH'(fp_q);
                    mv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Divider / converter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            fp_q    <= '0;
            mu_q    <= '0;
            mv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            fp_q    <= fp_d;
            mu_q    <= mu_d;
            mv_q    <= mv_d;
        end
    end

    assign nco_uf   = uf_q;
    assign mu       = mu_q;
    assign mu_valid = mv_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_timing_nco.sv
// Directed bench for timing_nco with a small eta/W reference model
// used for the random-step section.
module tb_timing_nco;

    logic        clk = 1'b0;
    logic        rst_n, en, ctrl_valid;
    logic [23:0] ctrl_word;
    logic        nco_uf, mu_valid, overrun;
    logic [18:0] mu;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    bit          mdl_on = 1'b0;
    logic [23:0] eta_m, w_m;
    int          due_q[$];
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    timing_nco #(.DATA_WIDTH(19), .NCO_WIDTH(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ctrl_word  (ctrl_word),
        .ctrl_valid (ctrl_valid),
        .nco_uf     (nco_uf),
        .mu         (mu),
        .mu_valid   (mu_valid),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] ref_fp(input logic [23:0] e,
                                           input logic [23:0] w);
        longint q;
        int     p;
        logic [9:0] m;
        q = (longint'(e) * 1024) / longint'(w);
        if (q == 0) return 19'h0;
        p = 0;
        for (int i = 0; i < 10; i++) if (q[i]) p = i;
        m = 10'(q << (10 - p));
        return {1'b0, 8'(117 + p), m};
    endfunction

    task automatic tick();
        logic uf;
        uf = 1'b0;
        if (mdl_on) begin
            uf = en && (w_m != 0) && (eta_m < w_m);
            if (uf) begin
                due_q.push_back(cyc_n + 13);
                exp_q.push_back(ref_fp(eta_m, w_m));
            end
            if (en) eta_m = eta_m - w_m;
            if (ctrl_valid) w_m = ctrl_word;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (mdl_on) begin
            chk("m_uf", 32'(nco_uf), 32'(uf));
            if (due_q.size() > 0 && due_q[0] == cyc_n) begin
                chk("m_mv", 32'(mu_valid), 1);
                chk("m_mu", 32'(mu), 32'(exp_q[0]));
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end else begin
                chk("m_mv", 32'(mu_valid), 0);
            end
        end
    endtask

    task automatic wait_sig(input bit sel_mv, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((sel_mv ? mu_valid : nco_uf) === 1'b1) begin
                at = cyc_n;
                break;
            end
        end
        if (at < 0) chk(sel_mv ? "tmo_mv" : "tmo_uf", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; ctrl_valid = 1'b0; ctrl_word = '0;
        tick();
        tick();
        chk("rst_uf", 32'(nco_uf), 0);
        chk("rst_mu", 32'(mu), 0);
        chk("rst_mv", 32'(mu_valid), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [23:0] w);
        ctrl_word = w; ctrl_valid = 1'b1;
        tick();
        ctrl_valid = 1'b0;
    endtask

    // Asynchronous reset pulse away from the clock edge
    task automatic pulse_rst(input string pfx);
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk({pfx, "_uf"}, 32'(nco_uf), 0);
        chk({pfx, "_mu"}, 32'(mu), 0);
        chk({pfx, "_mv"}, 32'(mu_valid), 0);
        chk({pfx, "_ovr"}, 32'(overrun), 0);
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (15) begin
            tick();
            n += int'(mu_valid);
        end
        chk({pfx, "_no_mv"}, n, 0);
    endtask

    task automatic run_029(input string pfx, output int e1);
        int t0, m1;
        load(24'h0C0000);
        en = 1'b1;
        t0 = cyc_n;
        wait_sig(1'b0, 40, e1);
        chk({pfx, "_uf_edge"}, e1 - t0, 11);
        wait_sig(1'b1, 20, m1);
        chk({pfx, "_mu_lat"}, m1 - e1, 12);
        chk({pfx, "_mu"}, 32'(mu), 32'h1F954);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int e1, e2, e3, e4, m, t0, n_uf, n_mv;
        logic [23:0] w;

        // Zero step never borrows
        do_reset();
        en = 1'b1;
        n_uf = 0;
        repeat (20) begin
            tick();
            n_uf += int'(nco_uf);
        end
        chk("w0_no_uf", n_uf, 0);

        // First underflow timing, then en pauses before and during a division
        do_reset();
        run_029("a", e1);
        tick();
        chk("a_mv_pulse", 32'(mu_valid), 0);
        chk("a_mu_hold", 32'(mu), 32'h1F954);
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        wait_sig(1'b0, 40, e2);
        chk("b_uf_delay", e2 - e1, 27);
        repeat (3) tick();
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        wait_sig(1'b1, 10, m);
        chk("b_mu_lat", m - e2, 12);
        chk("b_mu", 32'(mu), 0);
        wait_sig(1'b0, 40, e3);
        chk("c_uf_delay", e3 - e2, 26);
        wait_sig(1'b1, 20, m);
        chk("c_mu_lat", m - e3, 12);
        chk("c_mu", 32'(mu), 32'h1F554);

        // Reset in the middle of a division clears mu at once
        wait_sig(1'b0, 40, e4);
        chk("c_uf2_delay", e4 - e3, 21);
        repeat (4) tick();
        pulse_rst("r1");

        // eta_prev of zero gives mu of zero
        do_reset();
        load(24'h100000);
        en = 1'b1;
        t0 = cyc_n;
        wait_sig(1'b0, 40, e1);
        chk("z_uf_edge", e1 - t0, 9);
        wait_sig(1'b1, 20, m);
        chk("z_mu_lat", m - e1, 12);
        chk("z_mu", 32'(mu), 0);

        // Underflows every 4 cycles: dropped events and sticky overrun
        do_reset();
        load(24'h400000);
        en = 1'b1;
        t0 = cyc_n;
        wait_sig(1'b0, 40, e1);
        chk("o_uf_edge", e1 - t0, 3);
        chk("o_ovr_pre", 32'(overrun), 0);
        n_uf = 0;
        n_mv = 0;
        repeat (16) begin
            tick();
            n_uf += int'(nco_uf);
            n_mv += int'(mu_valid);
        end
        chk("o_n_mv", n_mv, 1);
        chk("o_n_uf", n_uf, 4);
        chk("o_ovr", 32'(overrun), 1);
        chk("o_uf_now", 32'(nco_uf), 1);
        pulse_rst("r2");
        run_029("d", e1);

        // Random steps against the reference model
        for (int k = 0; k < 6; k++) begin
            w = (k == 0) ? 24'd1290555 : 24'($urandom_range(1290555, 838861));
            do_reset();
            eta_m = 24'h800000;
            w_m = '0;
            due_q.delete();
            exp_q.delete();
            mdl_on = 1'b1;
            load(w);
            en = 1'b1;
            repeat (260) tick();
            mdl_on = 1'b0;
            en = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
